approx_add_lpp: RTL and testbench

//  Pipelined, parametrised lower-part-OR approximate adder with a runtime-selectable approximation depth.

---
 rtl/approx_add_pkg.sv | 32 +++
 rtl/approx_err_stats.sv | 78 +++++++
 rtl/approx_add_lpp.sv | 136 +++++++++++++
 tb/tb_approx_add_lpp.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_add_pkg.sv
// Shared helpers for the lower-part-OR approximate adder: k clamping and the
// LOA arithmetic itself, written once for any operand width up to MAX_W.
package approx_add_pkg;

  localparam int MAX_W     = 32;
  localparam int LPP_MAX_K = 4;
  localparam int K_W       = $clog2(LPP_MAX_K + 1);

  typedef logic [MAX_W:0] wide_t;

  function automatic int clamp_k(input int k, input int max_k);
    return (k > max_k) ? max_k : k;
  endfunction

  // Low k bits are a|b; the carry into the exact upper adder is a[k-1]&b[k-1].
  function automatic wide_t loa_add(input logic [MAX_W-1:0] a,
                                    input logic [MAX_W-1:0] b,
                                    input int               k);
    wide_t            mask;
    wide_t            lo;
    wide_t            hi;
    logic [MAX_W-1:0] top_bit;
    logic             cin;
    mask    = (wide_t'(1) << k) - wide_t'(1);
    lo      = {1'b0, a | b} & mask;
    top_bit = mask[MAX_W-1:0] ^ (mask[MAX_W-1:0] >> 1);
    cin     = |(a & b & top_bit);
    hi      = (({1'b0, a} >> k) + ({1'b0, b} >> k) + wide_t'(cin)) << k;
    return hi | lo;
  endfunction

endpackage

// File: rtl/approx_err_stats.sv
// On-line error statistics for the approximate adder: sample count, error
// count, saturating |error| sum and worst-case |error|.
module approx_err_stats
  import approx_add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SUM_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             fire,
  input  logic [WIDTH:0]   err,
  output logic [SUM_W-1:0] samples,
  output logic [SUM_W-1:0] errcnt,
  output logic [SUM_W-1:0] errsum,
  output logic [WIDTH:0]   errmax
);

  localparam int AW = ((SUM_W > WIDTH + 1) ? SUM_W : WIDTH + 1) + 1;
  localparam logic [SUM_W-1:0] ALL_ONES = '1;

  logic [SUM_W-1:0] samples_q, samples_d;
  logic [SUM_W-1:0] errcnt_q,  errcnt_d;
  logic [SUM_W-1:0] errsum_q,  errsum_d;
  logic [WIDTH:0]   errmax_q,  errmax_d;

  logic [SUM_W-1:0] samples_base;
  logic [SUM_W-1:0] errcnt_base;
  logic [SUM_W-1:0] errsum_base;
  logic [WIDTH:0]   errmax_base;
  logic [AW-1:0]    sum_wide;

  // A clear coinciding with a fire restarts the statistics from that sample.
  always_comb begin
    samples_base = clr ? '0 : samples_q;
    errcnt_base  = clr ? '0 : errcnt_q;
    errsum_base  = clr ? '0 : errsum_q;
    errmax_base  = clr ? '0 : errmax_q;
    samples_d    = samples_base;
    errcnt_d     = errcnt_base;
    errsum_d     = errsum_base;
    errmax_d     = errmax_base;
    sum_wide     = AW'(errsum_base) + AW'(err);
    if (fire) begin
      if (samples_base != ALL_ONES) begin
        samples_d = samples_base + SUM_W'(1);
      end
      if ((err != '0) && (errcnt_base != ALL_ONES)) begin
        errcnt_d = errcnt_base + SUM_W'(1);
      end
      errsum_d = (sum_wide > AW'(ALL_ONES)) ? ALL_ONES : sum_wide[SUM_W-1:0];
      if (err > errmax_base) begin
        errmax_d = err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samples_q <= '0;
      errcnt_q  <= '0;
      errsum_q  <= '0;
      errmax_q  <= '0;
    end else begin
      samples_q <= samples_d;
      errcnt_q  <= errcnt_d;
      errsum_q  <= errsum_d;
      errmax_q  <= errmax_d;
    end
  end

  assign samples = samples_q;
  assign errcnt  = errcnt_q;
  assign errsum  = errsum_q;
  assign errmax  = errmax_q;

endmodule

// File: rtl/approx_add_lpp.sv
// Two-stage elastic lower-part-OR approximate adder with a bit-exact shadow
// sum and error statistics gathered on every delivered result.
module approx_add_lpp
  import approx_add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_K = 4,
  parameter int SUM_W = 24,
  localparam int KW   = (MAX_K < 1) ? 1 : $clog2(MAX_K + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [KW-1:0]    in_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [WIDTH:0]   out_exact,
  input  logic             stats_clr,
  output logic [SUM_W-1:0] st_samples,
  output logic [SUM_W-1:0] st_errcnt,
  output logic [SUM_W-1:0] st_errsum,
  output logic [WIDTH:0]   st_errmax
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. A stage loads when empty or when its content leaves that same
  // cycle; in_ready depends on out_ready and stage state only, never in_valid.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [KW-1:0]    s1_k_q,     s1_k_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH:0]   s2_sum_q,   s2_sum_d;
  logic [WIDTH:0]   s2_exact_q, s2_exact_d;
  logic [WIDTH:0]   s2_err_q,   s2_err_d;

  logic             in_fire;
  logic             s2_load;
  logic             out_fire;
  logic [KW-1:0]    k_clamped;
  logic [WIDTH:0]   approx_sum;
  logic [WIDTH:0]   exact_sum;
  logic [WIDTH:0]   abs_err;

  always_comb begin
    out_fire  = s2_valid_q & out_ready;
    s2_load   = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready  = ~rst & (~s1_valid_q | s2_load);
    in_fire   = in_valid & in_ready;
    k_clamped = KW'(clamp_k(int'(in_k), MAX_K));
  end

  // Datapath between S1 and S2: approximate and exact sums of the held pair.
  always_comb begin
    approx_sum = (WIDTH+1)'(loa_add(MAX_W'(s1_a_q), MAX_W'(s1_b_q), int'(s1_k_q)));
    exact_sum  = (WIDTH+1)'(loa_add(MAX_W'(s1_a_q), MAX_W'(s1_b_q), 0));
    abs_err    = (approx_sum >= exact_sum) ? (approx_sum - exact_sum)
                                           : (exact_sum - approx_sum);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_k_d     = s1_k_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_k_d     = k_clamped;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_exact_d = s2_exact_q;
    s2_err_d   = s2_err_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_sum_d   = approx_sum;
      s2_exact_d = exact_sum;
      s2_err_d   = abs_err;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_k_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_exact_q <= '0;
      s2_err_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_k_q     <= s1_k_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_exact_q <= s2_exact_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;
  assign out_exact = s2_exact_q;

  approx_err_stats #(
    .WIDTH (WIDTH),
    .SUM_W (SUM_W)
  ) u_stats (
    .clk     (clk),
    .rst     (rst),
    .clr     (stats_clr),
    .fire    (out_fire),
    .err     (s2_err_q),
    .samples (st_samples),
    .errcnt  (st_errcnt),
    .errsum  (st_errsum),
    .errmax  (st_errmax)
  );

endmodule

// File: tb/tb_approx_add_lpp.sv
// Bench for approx_add_lpp: directed vector table, handshake/reset/clear
// sequences, random stream against a behavioural model, and a narrow-counter
// instance for saturation.
module tb_approx_add_lpp;
  import approx_add_pkg::*;

  localparam int W   = 8;
  localparam int MK  = LPP_MAX_K;
  localparam int SW  = 24;
  localparam int SW2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, in_ready, out_valid, out_ready, stats_clr;
  logic [W-1:0]   in_a, in_b;
  logic [K_W-1:0] in_k;
  logic [W:0]     out_sum, out_exact, st_errmax;
  logic [SW-1:0]  st_samples, st_errcnt, st_errsum;

  logic           rst2, in_valid2, in_ready2, out_valid2, out_ready2, stats_clr2;
  logic [W-1:0]   in_a2, in_b2;
  logic [K_W-1:0] in_k2;
  logic [W:0]     out_sum2, out_exact2, st_errmax2;
  logic [SW2-1:0] st_samples2, st_errcnt2, st_errsum2;

  approx_add_lpp #(.WIDTH(W), .MAX_K(MK), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_k(in_k), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_exact(out_exact),
    .stats_clr(stats_clr), .st_samples(st_samples), .st_errcnt(st_errcnt),
    .st_errsum(st_errsum), .st_errmax(st_errmax));

  approx_add_lpp #(.WIDTH(W), .MAX_K(MK), .SUM_W(SW2)) dut_sat (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .in_k(in_k2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_sum(out_sum2), .out_exact(out_exact2),
    .stats_clr(stats_clr2), .st_samples(st_samples2), .st_errcnt(st_errcnt2),
    .st_errsum(st_errsum2), .st_errmax(st_errmax2));

  typedef struct {
    int a;
    int b;
    int k;
    int exp_sum;
    int exp_exact;
  } vec_t;

  logic [2*W+1:0] exp_q[$];
  logic [2*W+1:0] hold_val;
  bit             hold_v;
  int n_cmp, n_bad;
  int m_samples, m_errcnt, m_errsum, m_errmax;
  localparam int SAT24 = (1 << SW) - 1;

  // Reference: k clamped, low k bits OR'd, carry from bit k-1 AND, rest added.
  function automatic int ref_sum(input int a, input int b, input int k);
    int kk, lo, cin, hi;
    kk  = (k > MK) ? MK : k;
    lo  = (a | b) % (1 << kk);
    cin = (kk == 0) ? 0 : (((a >> (kk - 1)) & (b >> (kk - 1))) & 1);
    hi  = ((a >> kk) + (b >> kk) + cin) * (1 << kk);
    return hi + lo;
  endfunction

  function automatic int abs_diff(input int x, input int y);
    return (x > y) ? x - y : y - x;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_samples = 0; m_errcnt = 0; m_errsum = 0; m_errmax = 0;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_samples"}, st_samples, m_samples);
    chk({tag, "_errcnt"},  st_errcnt,  m_errcnt);
    chk({tag, "_errsum"},  st_errsum,  m_errsum);
    chk({tag, "_errmax"},  st_errmax,  m_errmax);
  endtask

  // Called at a falling edge: apply inputs, account for the coming edge's fires.
  task automatic drive(input bit v, input int a, input int b, input int k,
                       input bit ordy, input bit clr, input int es, input int ee);
    logic [2*W+1:0] e;
    int err;
    in_valid = v; in_a = W'(a); in_b = W'(b); in_k = K_W'(k);
    out_ready = ordy; stats_clr = clr;
    #1;
    if (hold_v) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", {out_sum, out_exact}, hold_val);
    end
    if (clr) model_clear();
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("stale_out_valid", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_sum", out_sum, e[2*W+1:W+1]);
        chk("out_exact", out_exact, e[W:0]);
        err = abs_diff(int'(e[2*W+1:W+1]), int'(e[W:0]));
        m_samples = sat(m_samples + 1, SAT24);
        if (err != 0) m_errcnt = sat(m_errcnt + 1, SAT24);
        m_errsum = sat(m_errsum + err, SAT24);
        if (err > m_errmax) m_errmax = err;
      end
    end
    if (v && in_ready) exp_q.push_back({(W+1)'(es), (W+1)'(ee)});
    hold_v   = out_valid && !out_ready;
    hold_val = {out_sum, out_exact};
    @(negedge clk);
  endtask

  task automatic drive_rand(input bit v, input int k, input bit ordy);
    int a, b;
    a = $urandom_range(0, (1 << W) - 1);
    b = $urandom_range(0, (1 << W) - 1);
    drive(v, a, b, k, ordy, 1'b0, ref_sum(a, b, k), a + b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
  endtask

  vec_t vecs[8];
  int   sat_cnt, sat_errcnt, sat_errsum, sat_errmax, sat_a, sat_b;

  initial begin
    n_cmp = 0; n_bad = 0; hold_v = 0; model_clear();
    rst = 1; in_valid = 0; in_a = '0; in_b = '0; in_k = '0; out_ready = 0; stats_clr = 0;
    rst2 = 1; in_valid2 = 0; in_a2 = '0; in_b2 = '0; in_k2 = '0; out_ready2 = 1; stats_clr2 = 0;

    vecs[0] = '{a: 'h07, b: 'h01, k: 3, exp_sum: 'h007, exp_exact: 'h008};
    vecs[1] = '{a: 'hFF, b: 'hFF, k: 3, exp_sum: 'h1FF, exp_exact: 'h1FE};
    vecs[2] = '{a: 'h03, b: 'h03, k: 3, exp_sum: 'h003, exp_exact: 'h006};
    vecs[3] = '{a: 'h05, b: 'h03, k: 7, exp_sum: 'h007, exp_exact: 'h008};
    vecs[4] = '{a: 'h5A, b: 'h3C, k: 0, exp_sum: 'h096, exp_exact: 'h096};
    vecs[5] = '{a: 'h01, b: 'h01, k: 1, exp_sum: 'h003, exp_exact: 'h002};
    vecs[6] = '{a: 'h80, b: 'h80, k: 4, exp_sum: 'h100, exp_exact: 'h100};
    vecs[7] = '{a: 'hFE, b: 'h03, k: 2, exp_sum: 'h103, exp_exact: 'h101};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_exact", out_exact, 0);
    check_stats("rst");
    rst = 0; rst2 = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++)
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].k, 1'b1, 1'b0, vecs[i].exp_sum, vecs[i].exp_exact);
    idle(4);
    chk("tbl_q_empty", exp_q.size(), 0);
    chk("tbl_samples", st_samples, 8);
    chk("tbl_errcnt", st_errcnt, 6);
    chk("tbl_errsum", st_errsum, 9);
    chk("tbl_errmax", st_errmax, 3);
    check_stats("tbl");

    // Clear on the same edge as an output fire carrying err=2
    drive(1'b1, 'hFE, 'h03, 2, 1'b1, 1'b0, 'h103, 'h101);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
    chk("clr_out_valid", out_valid, 1);
    drive(1'b0, 0, 0, 0, 1'b1, 1'b1, 0, 0);
    chk("clr_samples", st_samples, 1);
    chk("clr_errcnt", st_errcnt, 1);
    chk("clr_errsum", st_errsum, 2);
    chk("clr_errmax", st_errmax, 2);

    // k=0 gives exact results
    drive(1'b0, 0, 0, 0, 1'b1, 1'b1, 0, 0);
    for (int i = 0; i < 256; i++) drive_rand(1'b1, 0, 1'b1);
    idle(4);
    chk("k0_samples", st_samples, 256);
    chk("k0_errcnt", st_errcnt, 0);
    chk("k0_errsum", st_errsum, 0);
    check_stats("k0");

    // Random stream with backpressure
    for (int i = 0; i < 400; i++)
      drive_rand($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("rand_q_empty", exp_q.size(), 0);
    idle(2);
    check_stats("rand");

    // Reset with two pairs in flight
    drive_rand(1'b1, 3, 1'b0);
    drive_rand(1'b1, 3, 1'b0);
    chk("pre_rst_out_valid", out_valid, 1);
    rst = 1; in_valid = 0; out_ready = 0;
    #1;
    chk("in_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 0;
    exp_q.delete(); hold_v = 0; model_clear();
    chk("midrst_out_valid", out_valid, 0);
    check_stats("midrst");
    idle(6);
    chk("midrst_no_stale", out_valid, 0);
    check_stats("midrst_after");

    // Saturation on the narrow-counter instance
    sat_cnt = 0; sat_errcnt = 0; sat_errsum = 0; sat_errmax = 0;
    for (int i = 0; i < 300; i++) begin
      sat_a = $urandom_range(0, 255);
      sat_b = $urandom_range(0, 255);
      in_valid2 = 1; in_a2 = W'(sat_a); in_b2 = W'(sat_b); in_k2 = K_W'(MK);
      #1;
      if (in_valid2 && in_ready2) begin
        sat_cnt++;
        if (abs_diff(ref_sum(sat_a, sat_b, MK), sat_a + sat_b) != 0) sat_errcnt++;
        sat_errsum += abs_diff(ref_sum(sat_a, sat_b, MK), sat_a + sat_b);
        if (abs_diff(ref_sum(sat_a, sat_b, MK), sat_a + sat_b) > sat_errmax)
          sat_errmax = abs_diff(ref_sum(sat_a, sat_b, MK), sat_a + sat_b);
      end
      @(negedge clk);
    end
    in_valid2 = 0;
    repeat (4) @(negedge clk);
    chk("sat_stream_count", sat_cnt, 300);
    chk("sat_samples", st_samples2, sat(sat_cnt, 255));
    chk("sat_errcnt", st_errcnt2, sat(sat_errcnt, 255));
    chk("sat_errsum", st_errsum2, sat(sat_errsum, 255));
    chk("sat_errmax", st_errmax2, sat_errmax);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
